ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_pkg.sv | 23 ++
 rtl/ram_port_arbiter_win.sv | 73 +++++++
 rtl/ram_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_pkg
// Shared definitions for the RAM port arbiter slice.
//   arb_state_t : arbiter ownership state (flash load, CPU run, halt pending,
//                 diagnostics halted)
//   DEF_*       : default parameter values used by the top and win_match
// ---------------------------------------------------------------------------
package ram_port_arbiter_pkg;

   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_N_WIN    = 2;
   localparam int DEF_WIN_AW   = 11;
   localparam int DEF_HALT_TMO = 1024;

   typedef enum logic [1:0] {
      ST_LOAD      = 2'd0,
      ST_RUN       = 2'd1,
      ST_HALT_PEND = 2'd2,
      ST_HALTED    = 2'd3
   } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_win.sv
// ---------------------------------------------------------------------------
// win_match
// One write-capture window: holds its [start, end) table entry, compares the
// muxed RAM write against it and registers the strobe plus window-local
// address.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   cfgWe_i                 : table write for this entry (already decoded)
//   cfgStart_i, cfgEnd_i    : new start / end (end exclusive)
//   ramAddr_i, ramCs_i,
//   ramWe_i                 : muxed RAM request being observed
//   winWe_o                 : registered hit strobe
//   winAddr_o               : registered (ramAddr - start), truncated
// WIN_AW is expected to be no wider than ADDR_W.
// ---------------------------------------------------------------------------
module win_match
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int WIN_AW = DEF_WIN_AW
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cfgWe_i,
   input  logic [ADDR_W-1:0] cfgStart_i,
   input  logic [ADDR_W-1:0] cfgEnd_i,
   input  logic [ADDR_W-1:0] ramAddr_i,
   input  logic              ramCs_i,
   input  logic              ramWe_i,
   output logic              winWe_o,
   output logic [WIN_AW-1:0] winAddr_o
);

   logic [ADDR_W-1:0] start_q;
   logic [ADDR_W-1:0] end_q;
   logic              winWe_q;
   logic [WIN_AW-1:0] winAddr_q;

   logic              enabled;
   logic              hit;
   logic [WIN_AW-1:0] winAddr_d;

   // A window with start >= end is treated as disabled. The hit is computed
   // from the table contents before any same-cycle config write lands.
   always_comb begin
      enabled   = (start_q < end_q);
      hit       = ramCs_i & ramWe_i & enabled &
                  (ramAddr_i >= start_q) & (ramAddr_i < end_q);
      winAddr_d = WIN_AW'(ramAddr_i - start_q);
   end

   // Table entry and output registers; the offset is registered every cycle
   // and is only meaningful alongside a strobe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         start_q   <= '0;
         end_q     <= '0;
         winWe_q   <= 1'b0;
         winAddr_q <= '0;
      end else begin
         if (cfgWe_i) begin
            start_q <= cfgStart_i;
            end_q   <= cfgEnd_i;
         end
         winWe_q   <= hit;
         winAddr_q <= winAddr_d;
      end
   end

   assign winWe_o   = winWe_q;
   assign winAddr_o = winAddr_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Arbitrates a single RAM port between a flash loader (at boot), the CPU bus
// (normal run) and a diagnostics port (while the CPU is halted), and mirrors
// every RAM write that lands in a configurable address window onto a
// registered capture port.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   load_done                        : flash image load finished
//   fl_*   / cpu_* / diag_*          : requestor address, wdata, cs, we
//   phi2                             : asynchronous CPU clock (halt point)
//   diag_halt_req                    : diagnostics wants the RAM (level)
//   ram_*                            : muxed RAM port (combinational)
//   rdy, halt_ack, cpu_oe            : CPU ready, diag owns RAM, CPU bus drive
//   win_cfg_we/idx/start/end         : window table write
//   win_we, win_addr, win_wdata      : registered window capture outputs
// ---------------------------------------------------------------------------
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int N_WIN    = DEF_N_WIN,
   parameter int WIN_AW   = DEF_WIN_AW,
   parameter int HALT_TMO = DEF_HALT_TMO,
   localparam int IDX_W   = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_done,
   input  logic [ADDR_W-1:0]       fl_addr,
   input  logic [DATA_W-1:0]       fl_wdata,
   input  logic                    fl_cs,
   input  logic                    fl_we,
   input  logic [ADDR_W-1:0]       cpu_addr,
   input  logic [DATA_W-1:0]       cpu_wdata,
   input  logic                    cpu_cs,
   input  logic                    cpu_we,
   input  logic                    phi2,
   input  logic                    diag_halt_req,
   input  logic [ADDR_W-1:0]       diag_addr,
   input  logic [DATA_W-1:0]       diag_wdata,
   input  logic                    diag_cs,
   input  logic                    diag_we,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       ram_wdata,
   output logic                    ram_cs,
   output logic                    ram_we,
   output logic                    rdy,
   output logic                    halt_ack,
   output logic                    cpu_oe,
   input  logic                    win_cfg_we,
   input  logic [IDX_W-1:0]        win_cfg_idx,
   input  logic [ADDR_W-1:0]       win_cfg_start,
   input  logic [ADDR_W-1:0]       win_cfg_end,
   output logic [N_WIN-1:0]        win_we,
   output logic [N_WIN*WIN_AW-1:0] win_addr,
   output logic [DATA_W-1:0]       win_wdata
);

   localparam int CNT_W = $clog2(HALT_TMO) + 1;

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic [CNT_W-1:0]  haltCnt_q;
   logic [CNT_W-1:0]  haltCnt_d;
   logic              phi2Meta_q;
   logic              phi2Sync_q;
   logic              phi2Prev_q;
   logic [DATA_W-1:0] winWdata_q;

   logic              phi2Fall;
   logic              haltTimeout;

   // phi2 is asynchronous: two flops to resolve metastability, a third to
   // remember the previous synchronised level for edge detection. All reset
   // high so that reset itself never looks like a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         phi2Meta_q <= 1'b1;
         phi2Sync_q <= 1'b1;
         phi2Prev_q <= 1'b1;
      end else begin
         phi2Meta_q <= phi2;
         phi2Sync_q <= phi2Meta_q;
         phi2Prev_q <= phi2Sync_q;
      end
   end

   assign phi2Fall    = phi2Prev_q & ~phi2Sync_q;
   assign haltTimeout = (haltCnt_q == CNT_W'(HALT_TMO - 1));

   // State and halt-timeout counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_LOAD;
         haltCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         haltCnt_q <= haltCnt_d;
      end
   end

   // Next-state logic. A withdrawn halt request wins over a phi2 edge or a
   // timeout seen in the same cycle. The counter only advances while a halt
   // is pending, so it always starts from zero on entry.
   always_comb begin
      state_d   = state_q;
      haltCnt_d = '0;
      case (state_q)
         ST_LOAD: begin
            if (load_done) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (diag_halt_req) begin
               state_d = ST_HALT_PEND;
            end
         end
         ST_HALT_PEND: begin
            haltCnt_d = haltCnt_q + 1'b1;
            if (!diag_halt_req) begin
               state_d = ST_RUN;
            end else if (phi2Fall || haltTimeout) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            if (!diag_halt_req) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // RAM port mux and CPU-side handshake outputs, purely from current state.
   // The CPU keeps the RAM while a halt is pending; it just is not ready.
   always_comb begin
      ram_addr  = fl_addr;
      ram_wdata = fl_wdata;
      ram_cs    = fl_cs;
      ram_we    = fl_we;
      rdy       = 1'b0;
      halt_ack  = 1'b0;
      cpu_oe    = 1'b0;
      case (state_q)
         ST_LOAD: begin
            ram_addr  = fl_addr;
            ram_wdata = fl_wdata;
            ram_cs    = fl_cs;
            ram_we    = fl_we;
         end
         ST_RUN: begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_cs    = cpu_cs;
            ram_we    = cpu_we;
            rdy       = 1'b1;
            cpu_oe    = cpu_cs & ~cpu_we;
         end
         ST_HALT_PEND: begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_cs    = cpu_cs;
            ram_we    = cpu_we;
         end
         ST_HALTED: begin
            ram_addr  = diag_addr;
            ram_wdata = diag_wdata;
            ram_cs    = diag_cs;
            ram_we    = diag_we;
            halt_ack  = 1'b1;
         end
         default: begin
            ram_cs = 1'b0;
            ram_we = 1'b0;
         end
      endcase
   end

   // Captured write data is shared by all windows; the per-window strobe
   // tells the consumer whether it applies.
   always_ff @(posedge clk) begin
      if (rst) begin
         winWdata_q <= '0;
      end else begin
         winWdata_q <= ram_wdata;
      end
   end

   assign win_wdata = winWdata_q;

   // One matcher per window. An index outside the table decodes to no entry,
   // so such config writes are dropped.
   for (genvar i = 0; i < N_WIN; i++) begin : g_win
      logic cfgSel;
      assign cfgSel = win_cfg_we && (32'(win_cfg_idx) == i);

      win_match #(
         .ADDR_W (ADDR_W),
         .WIN_AW (WIN_AW)
      ) u_win_match (
         .clk_i      (clk),
         .rst_i      (rst),
         .cfgWe_i    (cfgSel),
         .cfgStart_i (win_cfg_start),
         .cfgEnd_i   (win_cfg_end),
         .ramAddr_i  (ram_addr),
         .ramCs_i    (ram_cs),
         .ramWe_i    (ram_we),
         .winWe_o    (win_we[i]),
         .winAddr_o  (win_addr[i*WIN_AW +: WIN_AW])
      );
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed self-checking bench for ram_port_arbiter. Inputs change on the
// falling clock edge; combinational outputs are sampled 1 time unit later and
// registered outputs at the falling edge after the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 8;
   localparam int N_WIN    = 2;
   localparam int WIN_AW   = 11;
   localparam int HALT_TMO = 32;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    load_done;
   logic [ADDR_W-1:0]       fl_addr;
   logic [DATA_W-1:0]       fl_wdata;
   logic                    fl_cs;
   logic                    fl_we;
   logic [ADDR_W-1:0]       cpu_addr;
   logic [DATA_W-1:0]       cpu_wdata;
   logic                    cpu_cs;
   logic                    cpu_we;
   logic                    phi2;
   logic                    diag_halt_req;
   logic [ADDR_W-1:0]       diag_addr;
   logic [DATA_W-1:0]       diag_wdata;
   logic                    diag_cs;
   logic                    diag_we;
   logic [ADDR_W-1:0]       ram_addr;
   logic [DATA_W-1:0]       ram_wdata;
   logic                    ram_cs;
   logic                    ram_we;
   logic                    rdy;
   logic                    halt_ack;
   logic                    cpu_oe;
   logic                    win_cfg_we;
   logic [0:0]              win_cfg_idx;
   logic [ADDR_W-1:0]       win_cfg_start;
   logic [ADDR_W-1:0]       win_cfg_end;
   logic [N_WIN-1:0]        win_we;
   logic [N_WIN*WIN_AW-1:0] win_addr;
   logic [DATA_W-1:0]       win_wdata;

   int checkCount = 0;
   int errorCount = 0;

   ram_port_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .N_WIN    (N_WIN),
      .WIN_AW   (WIN_AW),
      .HALT_TMO (HALT_TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .load_done     (load_done),
      .fl_addr       (fl_addr),
      .fl_wdata      (fl_wdata),
      .fl_cs         (fl_cs),
      .fl_we         (fl_we),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_cs        (cpu_cs),
      .cpu_we        (cpu_we),
      .phi2          (phi2),
      .diag_halt_req (diag_halt_req),
      .diag_addr     (diag_addr),
      .diag_wdata    (diag_wdata),
      .diag_cs       (diag_cs),
      .diag_we       (diag_we),
      .ram_addr      (ram_addr),
      .ram_wdata     (ram_wdata),
      .ram_cs        (ram_cs),
      .ram_we        (ram_we),
      .rdy           (rdy),
      .halt_ack      (halt_ack),
      .cpu_oe        (cpu_oe),
      .win_cfg_we    (win_cfg_we),
      .win_cfg_idx   (win_cfg_idx),
      .win_cfg_start (win_cfg_start),
      .win_cfg_end   (win_cfg_end),
      .win_we        (win_we),
      .win_addr      (win_addr),
      .win_wdata     (win_wdata)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Drive one requestor set; unused requestors are parked idle.
   task automatic applyStimulus(input logic [1:0] who, input logic [15:0] addr,
                                input logic [7:0] data, input logic cs,
                                input logic we);
      fl_addr   = '0; fl_wdata   = '0; fl_cs   = 1'b0; fl_we   = 1'b0;
      cpu_addr  = '0; cpu_wdata  = '0; cpu_cs  = 1'b0; cpu_we  = 1'b0;
      diag_addr = '0; diag_wdata = '0; diag_cs = 1'b0; diag_we = 1'b0;
      case (who)
         2'd0: begin fl_addr = addr; fl_wdata = data; fl_cs = cs; fl_we = we; end
         2'd1: begin cpu_addr = addr; cpu_wdata = data; cpu_cs = cs; cpu_we = we; end
         default: begin diag_addr = addr; diag_wdata = data; diag_cs = cs; diag_we = we; end
      endcase
   endtask

   // One-cycle window table write starting at the current falling edge.
   task automatic applyWinCfg(input logic idx, input logic [15:0] s,
                              input logic [15:0] e);
      win_cfg_we    = 1'b1;
      win_cfg_idx   = idx;
      win_cfg_start = s;
      win_cfg_end   = e;
      @(negedge clk);
      win_cfg_we    = 1'b0;
   endtask

   // Hard stop in case the bench itself stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   logic [15:0] wAddr [4];
   logic [1:0]  wExpWe[4];
   int          cnt;
   logic        sawAck;

   initial begin
      wAddr  = '{16'h87FE, 16'h87FF, 16'h8800, 16'h8801};
      wExpWe = '{2'b01, 2'b11, 2'b10, 2'b00};

      rst = 1'b1; load_done = 1'b0; phi2 = 1'b1; diag_halt_req = 1'b0;
      win_cfg_we = 1'b0; win_cfg_idx = '0; win_cfg_start = '0; win_cfg_end = '0;
      applyStimulus(2'd0, 16'h0ABC, 8'h00, 1'b0, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_rdy", rdy, 0);
      checkOutput("reset_halt_ack", halt_ack, 0);
      checkOutput("reset_cpu_oe", cpu_oe, 0);
      checkOutput("reset_win_we", win_we, 0);
      checkOutput("reset_win_addr", win_addr, 0);
      checkOutput("reset_win_wdata", win_wdata, 0);
      checkOutput("reset_ram_addr_fl", ram_addr, 16'h0ABC);

      // Boot: flash write captured by window 0
      @(negedge clk);
      rst = 1'b0;
      applyWinCfg(1'b0, 16'h8000, 16'h8800);
      applyStimulus(2'd0, 16'h8000, 8'h5A, 1'b1, 1'b1);
      #1;
      checkOutput("boot_ram_addr", ram_addr, 16'h8000);
      checkOutput("boot_ram_wdata", ram_wdata, 8'h5A);
      checkOutput("boot_ram_cs_we", {ram_cs, ram_we}, 2'b11);
      checkOutput("boot_rdy", rdy, 0);
      @(negedge clk);
      applyStimulus(2'd0, 16'h0000, 8'h11, 1'b1, 1'b1);
      #1;
      checkOutput("boot_win_we", win_we, 2'b01);
      checkOutput("boot_win_addr0", win_addr[10:0], 11'h000);
      checkOutput("boot_win_wdata", win_wdata, 8'h5A);
      @(negedge clk);
      applyStimulus(2'd0, 16'h0000, 8'h00, 1'b0, 1'b0);
      #1;
      checkOutput("disabled_win_no_strobe", win_we, 2'b00);

      // load_done -> RUN on the next cycle; later deassertion is ignored
      load_done = 1'b1;
      #1;
      checkOutput("load_rdy_same_cycle", rdy, 0);
      @(negedge clk);
      #1;
      checkOutput("load_rdy_next_cycle", rdy, 1);
      load_done = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("load_done_drop_ignored", rdy, 1);

      // CPU read / write in RUN
      applyStimulus(2'd1, 16'h4321, 8'h00, 1'b1, 1'b0);
      #1;
      checkOutput("run_ram_addr", ram_addr, 16'h4321);
      checkOutput("run_cpu_oe_read", cpu_oe, 1);
      applyStimulus(2'd1, 16'h4321, 8'h77, 1'b1, 1'b1);
      #1;
      checkOutput("run_cpu_oe_write", cpu_oe, 0);
      checkOutput("run_ram_wdata", ram_wdata, 8'h77);
      @(negedge clk);
      applyStimulus(2'd1, 16'h0000, 8'h00, 1'b0, 1'b0);

      // Window boundaries with overlapping windows 0 and 1
      applyWinCfg(1'b1, 16'h87FF, 16'h8801);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'd1, wAddr[i], 8'(8'h10 + i), 1'b1, 1'b1);
         @(negedge clk);
         #1;
         checkOutput($sformatf("win_we_%0h", wAddr[i]), win_we, wExpWe[i]);
         checkOutput($sformatf("win_wdata_%0h", wAddr[i]), win_wdata, 8'(8'h10 + i));
         if (wExpWe[i][0])
            checkOutput($sformatf("win_addr0_%0h", wAddr[i]), win_addr[10:0],
                        11'(wAddr[i] - 16'h8000));
         if (wExpWe[i][1])
            checkOutput($sformatf("win_addr1_%0h", wAddr[i]), win_addr[21:11],
                        11'(wAddr[i] - 16'h87FF));
      end

      // Config write coinciding with a RAM write uses the old table entry
      applyStimulus(2'd1, 16'h9000, 8'h33, 1'b1, 1'b1);
      applyWinCfg(1'b0, 16'h9000, 16'h9100);
      #1;
      checkOutput("cfg_same_cycle_old_table", win_we, 2'b00);
      @(negedge clk);
      #1;
      checkOutput("cfg_next_cycle_new_table", win_we, 2'b01);
      checkOutput("cfg_next_cycle_addr0", win_addr[10:0], 11'h000);
      applyStimulus(2'd1, 16'h0000, 8'h00, 1'b0, 1'b0);

      // Halt via phi2 falling edge
      @(negedge clk);
      diag_halt_req = 1'b1;
      #1;
      checkOutput("halt_req_rdy_still_run", rdy, 1);
      @(negedge clk);
      applyStimulus(2'd1, 16'h2222, 8'h00, 1'b1, 1'b0);
      #1;
      checkOutput("halt_pend_rdy", rdy, 0);
      checkOutput("halt_pend_ram_cpu", ram_addr, 16'h2222);
      phi2 = 1'b0;
      cnt = 0;
      while (halt_ack !== 1'b1 && cnt < 10) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      checkOutput("halt_ack_within_3", (cnt >= 1 && cnt <= 3), 1);
      applyStimulus(2'd2, 16'h1234, 8'h00, 1'b1, 1'b0);
      cpu_addr = 16'h5555; cpu_cs = 1'b1; cpu_we = 1'b0;
      #1;
      checkOutput("halted_ram_addr_diag", ram_addr, 16'h1234);
      checkOutput("halted_ram_we", ram_we, 0);
      checkOutput("halted_cpu_oe", cpu_oe, 0);
      checkOutput("halted_rdy", rdy, 0);
      phi2 = 1'b1;
      diag_halt_req = 1'b0;
      applyStimulus(2'd1, 16'h0000, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("release_rdy", rdy, 1);
      checkOutput("release_halt_ack", halt_ack, 0);

      // Timeout with phi2 held high
      repeat (4) @(negedge clk);
      diag_halt_req = 1'b1;
      @(negedge clk);
      #1;
      cnt = 0;
      while (halt_ack !== 1'b1 && cnt < HALT_TMO + 8) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      checkOutput("timeout_cycles", cnt, HALT_TMO);
      diag_halt_req = 1'b0;
      @(negedge clk);

      // Withdraw in the very cycle the timeout would fire
      @(negedge clk);
      diag_halt_req = 1'b1;
      sawAck = 1'b0;
      @(negedge clk);
      repeat (HALT_TMO - 1) begin
         @(negedge clk);
         #1;
         if (halt_ack) sawAck = 1'b1;
      end
      checkOutput("withdraw_pend_rdy", rdy, 0);
      diag_halt_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (halt_ack) sawAck = 1'b1;
      end
      checkOutput("withdraw_rdy", rdy, 1);
      checkOutput("withdraw_no_ack", sawAck, 0);

      // Reset while halted
      diag_halt_req = 1'b1;
      @(negedge clk);
      phi2 = 1'b0;
      cnt = 0;
      while (halt_ack !== 1'b1 && cnt < 10) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      checkOutput("halted_before_reset", halt_ack, 1);
      rst = 1'b1;
      applyStimulus(2'd0, 16'h0ABC, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("rst_halted_rdy", rdy, 0);
      checkOutput("rst_halted_halt_ack", halt_ack, 0);
      checkOutput("rst_halted_ram_fl", ram_addr, 16'h0ABC);
      checkOutput("rst_halted_win_we", win_we, 0);
      rst = 1'b0;
      diag_halt_req = 1'b0;
      phi2 = 1'b1;
      applyStimulus(2'd0, 16'h9000, 8'h44, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("rst_windows_disabled", win_we, 0);
      checkOutput("rst_stays_load", rdy, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
